// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the data cache controller.
// The cache is the slave; the pipeline/memory environment is the master.
interface dcache_ctrl_if;
  logic         C_READ;
  logic         C_WRITE;
  logic [31:0]  C_ADDRESS;
  logic [31:0]  C_WRITEDATA;
  logic [31:0]  C_READDATA;
  logic         C_BUSYWAIT;
  logic         M_READ;
  logic         M_WRITE;
  logic [27:0]  M_ADDRESS;
  logic [127:0] M_WRITEDATA;
  logic [127:0] M_READDATA;

  modport slave (
    input  C_READ, C_WRITE, C_ADDRESS, C_WRITEDATA, M_READDATA,
    output C_READDATA, C_BUSYWAIT,
    output M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
  );

  modport master (
    output C_READ, C_WRITE, C_ADDRESS, C_WRITEDATA, M_READDATA,
    input  C_READDATA, C_BUSYWAIT,
    input  M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller.
// Fixed-latency memory strobes pace line fills and dirty evictions.
module dcache_ctrl #(
  parameter int SETS        = 8,
  parameter int MEM_LATENCY = 80
) (
  input logic          CLOCK,
  input logic          RESET,
  dcache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;
  localparam int CNT_W = $clog2(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE, WRITEBACK, GAP, ALLOCATE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [SETS-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q [SETS];
  logic [TAG_W-1:0]   tag_d [SETS];
  logic [127:0]       data_q [SETS];
  logic [127:0]       data_d [SETS];
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic               m_read_q, m_read_d;
  logic               m_write_q, m_write_d;
  logic [27:0]        m_addr_q, m_addr_d;
  logic [127:0]       m_wdata_q, m_wdata_d;

  logic               req;
  logic               hit;
  logic [1:0]         word;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [31:0]        line_word;
  logic               unused_addr;

  // Split the CPU address and look up the indexed line.
  always_comb begin
    req       = bus.C_READ | bus.C_WRITE;
    word      = bus.C_ADDRESS[3:2];
    idx       = bus.C_ADDRESS[IDX_W+3:4];
    tag       = bus.C_ADDRESS[31:IDX_W+4];
    hit       = valid_q[idx] && (tag_q[idx] == tag);
    line_word = data_q[idx][{word, 5'b0} +: 32];
  end

  assign unused_addr = ^bus.C_ADDRESS[1:0];

  assign bus.C_BUSYWAIT  = req && !((state_q == IDLE) && hit);
  assign bus.C_READDATA  = (bus.C_READ && !bus.C_WRITE && hit &&
                            (state_q == IDLE)) ? line_word : 32'h0;
  assign bus.M_READ      = m_read_q;
  assign bus.M_WRITE     = m_write_q;
  assign bus.M_ADDRESS   = m_addr_q;
  assign bus.M_WRITEDATA = m_wdata_q;

  // Next-state, strobe and line-update logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    m_read_d   = m_read_q;
    m_write_d  = m_write_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          if (bus.C_WRITE) begin
            data_d[idx][{word, 5'b0} +: 32] = bus.C_WRITEDATA;
            dirty_d[idx] = 1'b1;
          end
        end else if (req) begin
          miss_tag_d = tag;
          miss_idx_d = idx;
          cnt_d      = '0;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d   = WRITEBACK;
            m_write_d = 1'b1;
            m_addr_d  = {tag_q[idx], idx};
            m_wdata_d = data_q[idx];
          end else begin
            state_d  = ALLOCATE;
            m_read_d = 1'b1;
            m_addr_d = {tag, idx};
          end
        end
      end
      WRITEBACK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d   = GAP;
          m_write_d = 1'b0;
          cnt_d     = '0;
        end
      end
      GAP: begin
        state_d  = ALLOCATE;
        m_read_d = 1'b1;
        m_addr_d = {miss_tag_q, miss_idx_q};
        cnt_d    = '0;
      end
      ALLOCATE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d             = IDLE;
          m_read_d            = 1'b0;
          cnt_d               = '0;
          data_d[miss_idx_q]  = bus.M_READDATA;
          tag_d[miss_idx_q]   = miss_tag_q;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, line flags and registered memory strobes.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  // Tag/data arrays; a reset cycle suppresses any pending line write.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a flat block-memory model.
// Load results are queued at issue and compared when busywait drops.
module tb_dcache_ctrl;
  localparam int LAT = 80;

  logic clk;
  logic rst;

  dcache_ctrl_if bus ();

  dcache_ctrl #(.SETS(8), .MEM_LATENCY(LAT)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [127:0] mem [256];
  logic [31:0]  golden [1024];
  logic [31:0]  sb [$];

  function automatic logic [31:0] pat(input int blk, input int w);
    if (blk == 4 && w == 2) return 32'h1234_5678;
    return 32'hC000_0000 | 32'(blk << 8) | 32'(w);
  endfunction

  assign bus.M_READDATA = mem[bus.M_ADDRESS[7:0]];

  always @(posedge clk) begin
    if (bus.M_WRITE) mem[bus.M_ADDRESS[7:0]] = bus.M_WRITEDATA;
  end

  int          rd_run = 0, wr_run = 0, gap_run = 0;
  int          last_rd_w = 0, last_wr_w = 0, last_gap = -1;
  int          rd_cnt = 0, wr_cnt = 0;
  bit          after_wr = 0, both_seen = 0;
  logic [27:0] rd_addr = '0, wr_addr = '0;
  logic [31:0] wr_word1 = '0;

  always @(negedge clk) begin
    if (bus.M_READ && bus.M_WRITE) both_seen = 1;
    if (bus.M_WRITE) begin
      if (wr_run == 0) begin
        wr_addr  = bus.M_ADDRESS;
        wr_word1 = bus.M_WRITEDATA[63:32];
      end
      wr_run++;
      gap_run  = 0;
      after_wr = 1;
    end else if (wr_run != 0) begin
      last_wr_w = wr_run;
      wr_cnt++;
      wr_run = 0;
    end
    if (!bus.M_WRITE && !bus.M_READ && after_wr) gap_run++;
    if (bus.M_READ) begin
      if (rd_run == 0) begin
        rd_addr = bus.M_ADDRESS;
        if (after_wr) begin
          last_gap = gap_run;
          after_wr = 0;
        end
      end
      rd_run++;
    end else if (rd_run != 0) begin
      last_rd_w = rd_run;
      rd_cnt++;
      rd_run = 0;
    end
  end

  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int stall);
    logic [31:0] exp;
    bus.C_READ      = rd;
    bus.C_WRITE     = wr;
    bus.C_ADDRESS   = a;
    bus.C_WRITEDATA = d;
    stall = 0;
    @(negedge clk);
    while (bus.C_BUSYWAIT && stall < 400) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= 400) chk("bwait_bound", 64'(bus.C_BUSYWAIT), 64'd0);
    if (rd && !wr) begin
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      chk("rdata", 64'(bus.C_READDATA), 64'(exp));
    end
    if (wr) golden[a[11:2]] = d;
    @(posedge clk);
    #1;
    bus.C_READ  = 1'b0;
    bus.C_WRITE = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output int stall);
    sb.push_back(golden[a[11:2]]);
    access(1'b1, 1'b0, a, 32'h0, stall);
  endtask

  int st;
  int wait_n;
  int rd_before;
  int wr_before;

  initial begin
    for (int b = 0; b < 256; b++) begin
      for (int w = 0; w < 4; w++) begin
        golden[b*4+w] = pat(b, w);
        mem[b][w*32 +: 32] = pat(b, w);
      end
    end
    rst             = 1'b1;
    bus.C_READ      = 1'b0;
    bus.C_WRITE     = 1'b0;
    bus.C_ADDRESS   = '0;
    bus.C_WRITEDATA = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mread", 64'(bus.M_READ), 64'd0);
    chk("rst_mwrite", 64'(bus.M_WRITE), 64'd0);
    chk("rst_maddr", 64'(bus.M_ADDRESS), 64'd0);
    chk("rst_mwdata", bus.M_WRITEDATA[63:0], 64'd0);
    chk("rst_bwait", 64'(bus.C_BUSYWAIT), 64'd0);
    @(posedge clk);
    #1;

    load(32'h48, st);
    chk("t1_stall", 64'(st), 64'(LAT + 1));
    chk("t1_rd_w", 64'(last_rd_w), 64'(LAT));
    chk("t1_rd_addr", 64'(rd_addr), 64'h4);

    rd_before = rd_cnt;
    access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, st);
    chk("t2_wr_stall", 64'(st), 64'd0);
    load(32'h44, st);
    chk("t2_rd_stall", 64'(st), 64'd0);
    chk("t2_no_strobe", 64'(rd_cnt + wr_cnt), 64'(rd_before));

    load(32'h444, st);
    chk("t3_stall", 64'(st), 64'(2 * LAT + 2));
    chk("t3_wr_w", 64'(last_wr_w), 64'(LAT));
    chk("t3_wr_addr", 64'(wr_addr), 64'h4);
    chk("t3_wr_data", 64'(wr_word1), 64'hDEAD_BEEF);
    chk("t3_gap", 64'(last_gap), 64'd1);
    chk("t3_rd_w", 64'(last_rd_w), 64'(LAT));
    chk("t3_rd_addr", 64'(rd_addr), 64'h44);

    access(1'b1, 1'b1, 32'h48, 32'hA5A5_A5A5, st);
    chk("t4_stall", 64'(st), 64'(LAT + 1));
    load(32'h48, st);
    chk("t4_rd_stall", 64'(st), 64'd0);
    load(32'h44, st);
    chk("t4_wb_stall", 64'(st), 64'd0);

    bus.C_READ    = 1'b1;
    bus.C_ADDRESS = 32'h100;
    wait_n = 0;
    @(negedge clk);
    while (!bus.M_READ && wait_n < 10) begin
      wait_n++;
      @(negedge clk);
    end
    chk("t5_fill_start", 64'(bus.M_READ), 64'd1);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_abort_mread", 64'(bus.M_READ), 64'd0);
    rst        = 1'b0;
    bus.C_READ = 1'b0;
    @(posedge clk);
    #1;
    load(32'h100, st);
    chk("t5_refill_stall", 64'(st), 64'(LAT + 1));
    chk("t5_refill_w", 64'(last_rd_w), 64'(LAT));

    wr_before     = wr_cnt;
    rd_before     = rd_cnt;
    bus.C_READ    = 1'b1;
    bus.C_ADDRESS = 32'h80;
    wait_n = 0;
    @(negedge clk);
    while (!bus.M_READ && wait_n < 10) begin
      wait_n++;
      @(negedge clk);
    end
    repeat (9) @(negedge clk);
    bus.C_READ = 1'b0;
    wait_n = 0;
    while (rd_cnt == rd_before && wait_n < 200) begin
      wait_n++;
      @(negedge clk);
    end
    chk("t6_fill_w", 64'(last_rd_w), 64'(LAT));
    chk("t6_rd_addr", 64'(rd_addr), 64'h8);
    chk("t6_idle_bwait", 64'(bus.C_BUSYWAIT), 64'd0);
    @(posedge clk);
    #1;
    load(32'h80, st);
    chk("t6_hit_stall", 64'(st), 64'd0);
    chk("t6_no_write", 64'(wr_cnt), 64'(wr_before));

    chk("strobe_excl", 64'(both_seen), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
